// File: rtl/csr_trap_sequencer.sv
// csr_trap_sequencer: owns mstatus/mtvec/mepc/mcause and serialises CSR-instruction, trap and mret access to them.
// Latency: CSR response 2 cycles after accept, trap redirect 3 cycles, mret redirect 1 cycle.
// Backpressure: every ready is low outside IDLE; in IDLE one request is taken per cycle (trap > mret > csr).
//
// Ports:
//   clock_i / reset_i           clock, synchronous active-low reset
//   csr_req_* / csr_resp_*      CSR instruction request (addr, op, wdata) and response (old value, illegal flag)
//   trap_* / mret_*             trap entry (cause, faulting pc) and mret requests
//   redirect_valid_o/_pc_o      one-cycle fetch redirect to trap vector or return pc
//   busy_o                      a sequence is in flight
//   regs_0_o..regs_3_o          live mstatus, mtvec, mepc, mcause
// Optional: define CSR_MSTATUS_STACK_EN to stack MIE/MPIE/MPP in mstatus on trap entry and mret.
module csr_trap_sequencer #(
    parameter int unsigned     XLEN        = 32,
    parameter logic [XLEN-1:0] MSTATUS_RST = XLEN'(32'h0000_1800),
    parameter logic [XLEN-1:0] MTVEC_RST   = '0
) (
    input  logic            clock_i,
    input  logic            reset_i,
    input  logic            csr_req_valid_i,
    output logic            csr_req_ready_o,
    input  logic [11:0]     csr_addr_i,
    input  logic [1:0]      csr_op_i,
    input  logic [XLEN-1:0] csr_wdata_i,
    output logic            csr_resp_valid_o,
    output logic [XLEN-1:0] csr_rdata_o,
    output logic            csr_illegal_o,
    input  logic            trap_valid_i,
    output logic            trap_ready_o,
    input  logic [XLEN-1:0] trap_cause_i,
    input  logic [XLEN-1:0] trap_pc_i,
    input  logic            mret_valid_i,
    output logic            mret_ready_o,
    output logic            redirect_valid_o,
    output logic [XLEN-1:0] redirect_pc_o,
    output logic            busy_o,
    output logic [XLEN-1:0] regs_0_o,
    output logic [XLEN-1:0] regs_1_o,
    output logic [XLEN-1:0] regs_2_o,
    output logic [XLEN-1:0] regs_3_o
);

    localparam logic [11:0] ADDR_MSTATUS = 12'h300;
    localparam logic [11:0] ADDR_MTVEC   = 12'h305;
    localparam logic [11:0] ADDR_MEPC    = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE  = 12'h342;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CSR_RMW,
        S_CSR_RESP,
        S_TRAP_EPC,
        S_TRAP_CAUSE,
        S_TRAP_DONE,
        S_MRET
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] mstatus_q, mstatus_d;
    logic [XLEN-1:0] mtvec_q, mtvec_d;
    logic [XLEN-1:0] mepc_q, mepc_d;
    logic [XLEN-1:0] mcause_q, mcause_d;

    // Latched request. opnd_q carries the CSR operand or the trap cause.
    logic [11:0]     addr_q, addr_d;
    logic [1:0]      op_q, op_d;
    logic [XLEN-1:0] opnd_q, opnd_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] rdata_q, rdata_d;
    logic            illegal_q, illegal_d;

    // Single register write port shared by the CSR and trap sequences.
    logic            wr_en;
    logic [11:0]     wr_addr;
    logic [XLEN-1:0] wr_data;

    logic            sel_legal;
    logic [XLEN-1:0] sel_old;
    logic [XLEN-1:0] rmw_new;

`ifdef CSR_MSTATUS_STACK_EN
    logic            stack_trap;
    logic            stack_mret;
`endif

    // Old value of the latched CSR address; unmapped addresses read 0.
    always_comb begin
        sel_legal = 1'b1;
        sel_old   = '0;
        case (addr_q)
            ADDR_MSTATUS: sel_old = mstatus_q;
            ADDR_MTVEC:   sel_old = mtvec_q;
            ADDR_MEPC:    sel_old = mepc_q;
            ADDR_MCAUSE:  sel_old = mcause_q;
            default:      sel_legal = 1'b0;
        endcase
    end

    always_comb begin
        case (op_q)
            2'b01:   rmw_new = opnd_q;
            2'b10:   rmw_new = sel_old | opnd_q;
            2'b11:   rmw_new = sel_old & ~opnd_q;
            default: rmw_new = sel_old;
        endcase
    end

    // FSM next state and outputs.
    always_comb begin
        state_d          = state_q;
        addr_d           = addr_q;
        op_d             = op_q;
        opnd_d           = opnd_q;
        pc_d             = pc_q;
        rdata_d          = rdata_q;
        illegal_d        = illegal_q;
        wr_en            = 1'b0;
        wr_addr          = addr_q;
        wr_data          = rmw_new;
        trap_ready_o     = 1'b0;
        mret_ready_o     = 1'b0;
        csr_req_ready_o  = 1'b0;
        csr_resp_valid_o = 1'b0;
        redirect_valid_o = 1'b0;
        redirect_pc_o    = '0;
`ifdef CSR_MSTATUS_STACK_EN
        stack_trap       = 1'b0;
        stack_mret       = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                trap_ready_o    = 1'b1;
                mret_ready_o    = !trap_valid_i;
                csr_req_ready_o = !trap_valid_i && !mret_valid_i;
                if (trap_valid_i) begin
                    opnd_d  = trap_cause_i;
                    pc_d    = trap_pc_i;
                    state_d = S_TRAP_EPC;
                end else if (mret_valid_i) begin
                    state_d = S_MRET;
                end else if (csr_req_valid_i) begin
                    addr_d  = csr_addr_i;
                    op_d    = csr_op_i;
                    opnd_d  = csr_wdata_i;
                    state_d = S_CSR_RMW;
                end
            end
            S_CSR_RMW: begin
                // Read-only op and unmapped addresses leave every register untouched.
                wr_en     = sel_legal && (op_q != 2'b00);
                rdata_d   = sel_old;
                illegal_d = !sel_legal;
                state_d   = S_CSR_RESP;
            end
            S_CSR_RESP: begin
                csr_resp_valid_o = 1'b1;
                state_d          = S_IDLE;
            end
            S_TRAP_EPC: begin
                wr_en   = 1'b1;
                wr_addr = ADDR_MEPC;
                wr_data = pc_q;
                state_d = S_TRAP_CAUSE;
            end
            S_TRAP_CAUSE: begin
                wr_en   = 1'b1;
                wr_addr = ADDR_MCAUSE;
                wr_data = opnd_q;
`ifdef CSR_MSTATUS_STACK_EN
                stack_trap = 1'b1;
`endif
                state_d = S_TRAP_DONE;
            end
            S_TRAP_DONE: begin
                redirect_valid_o = 1'b1;
                redirect_pc_o    = {mtvec_q[XLEN-1:2], 2'b00};
                state_d          = S_IDLE;
            end
            S_MRET: begin
                redirect_valid_o = 1'b1;
                redirect_pc_o    = mepc_q;
`ifdef CSR_MSTATUS_STACK_EN
                stack_mret = 1'b1;
`endif
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Write port decode; mtvec and mepc are always word aligned.
    always_comb begin
        mstatus_d = mstatus_q;
        mtvec_d   = mtvec_q;
        mepc_d    = mepc_q;
        mcause_d  = mcause_q;
        if (wr_en) begin
            case (wr_addr)
                ADDR_MSTATUS: mstatus_d = wr_data;
                ADDR_MTVEC:   mtvec_d   = {wr_data[XLEN-1:2], 2'b00};
                ADDR_MEPC:    mepc_d    = {wr_data[XLEN-1:2], 2'b00};
                ADDR_MCAUSE:  mcause_d  = wr_data;
                default:      ;
            endcase
        end
`ifdef CSR_MSTATUS_STACK_EN
        // Interrupt-enable stacking is a side path alongside the mcause/redirect step.
        if (stack_trap) begin
            mstatus_d[7]     = mstatus_q[3];
            mstatus_d[3]     = 1'b0;
            mstatus_d[12:11] = 2'b11;
        end
        if (stack_mret) begin
            mstatus_d[3]     = mstatus_q[7];
            mstatus_d[7]     = 1'b1;
            mstatus_d[12:11] = 2'b11;
        end
`endif
    end

    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            state_q   <= S_IDLE;
            mstatus_q <= MSTATUS_RST;
            mtvec_q   <= MTVEC_RST;
            mepc_q    <= '0;
            mcause_q  <= '0;
            addr_q    <= '0;
            op_q      <= '0;
            opnd_q    <= '0;
            pc_q      <= '0;
            rdata_q   <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mstatus_q <= mstatus_d;
            mtvec_q   <= mtvec_d;
            mepc_q    <= mepc_d;
            mcause_q  <= mcause_d;
            addr_q    <= addr_d;
            op_q      <= op_d;
            opnd_q    <= opnd_d;
            pc_q      <= pc_d;
            rdata_q   <= rdata_d;
            illegal_q <= illegal_d;
        end
    end

    assign csr_rdata_o   = rdata_q;
    assign csr_illegal_o = (state_q == S_CSR_RESP) && illegal_q;
    assign busy_o        = (state_q != S_IDLE);
    assign regs_0_o      = mstatus_q;
    assign regs_1_o      = mtvec_q;
    assign regs_2_o      = mepc_q;
    assign regs_3_o      = mcause_q;

endmodule

// File: doc/csr_trap_sequencer.md
Name: csr_trap_sequencer

Overview:
- Owns the four machine-mode CSRs: mstatus, mtvec, mepc and mcause.
- Sequences all access to them from two requesters: the core's CSR-instruction port, and the trap/mret port from the exception logic.
- Single write port; trap entry is split into multi-cycle micro-steps.
- Exports the four register values (regs_0..regs_3) straight to the CSR debug-display block and the difftest hooks.

Parameters:
- XLEN, 32, data width of every CSR and data port.
- MSTATUS_RST, 32'h00001800, reset value of mstatus (MPP=11).
- MTVEC_RST, 32'h00000000, reset value of mtvec.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset; state clears on a rising edge where reset==0.
- csr_req_valid  in  1  CSR instruction request.
- csr_req_ready  out  1  request accepted when valid&ready.
- csr_addr  in  12  CSR address.
- csr_op  in  2  01=RW, 10=RS (set), 11=RC (clear), 00=read-only.
- csr_wdata  in  XLEN  rs1/imm operand.
- csr_resp_valid  out  1  one-cycle pulse; csr_rdata valid.
- csr_rdata  out  XLEN  old CSR value.
- csr_illegal  out  1  qualifies csr_resp_valid: address unmapped.
- trap_valid  in  1  exception/ecall request.
- trap_ready  out  1  trap accepted.
- trap_cause  in  XLEN  mcause value.
- trap_pc  in  XLEN  faulting PC.
- mret_valid  in  1  mret request.
- mret_ready  out  1  mret accepted.
- redirect_valid  out  1  one-cycle pulse; fetch must jump to redirect_pc.
- redirect_pc  out  XLEN  trap vector or return PC.
- busy  out  1  state != IDLE.
- regs_0..regs_3  out  XLEN each  mstatus, mtvec, mepc, mcause (live register values).

Behaviour:
Reset (reset==0 at edge):
- state=IDLE.
- mstatus=MSTATUS_RST, mtvec=MTVEC_RST, mepc=0, mcause=0.
- All pulse outputs are 0; csr_rdata=0.
- Reset mid-operation abandons any in-flight sequence; no partial write survives past the reset values.

Address map:
- 0x300 mstatus, 0x305 mtvec, 0x341 mepc, 0x342 mcause.
- Any other address reads 0, writes nothing, and sets csr_illegal=1 together with csr_resp_valid.

Arbitration (IDLE only; priority trap > mret > csr):
- trap_ready = (state==IDLE).
- mret_ready = IDLE & !trap_valid.
- csr_req_ready = IDLE & !trap_valid & !mret_valid.
- All ready signals are 0 outside IDLE; requesters hold valid until accepted.

FSM:
- IDLE:
  - On csr accept: latch addr/op/wdata, go to CSR_RMW.
  - On trap accept: latch cause/pc, go to TRAP_EPC.
  - On mret accept: go to MRET.
- CSR_RMW:
  - old = selected CSR value.
  - new = wdata (RW), old|wdata (RS), old&~wdata (RC), or old (op 00, no write).
  - Write new, csr_rdata<=old, go to CSR_RESP.
- CSR_RESP: csr_resp_valid=1; go to IDLE.
- TRAP_EPC: mepc <= {pc[31:2],2'b00}; go to TRAP_CAUSE.
- TRAP_CAUSE: mcause <= cause; go to TRAP_DONE.
- TRAP_DONE: redirect_valid=1, redirect_pc={mtvec[31:2],2'b00}; go to IDLE.
- MRET: redirect_valid=1, redirect_pc=mepc; go to IDLE.

Latency (cycles from accept edge):
- CSR op: response 2.
- Trap: redirect 3.
- Mret: redirect 1.

Write rules:
- Writes to mepc force bits[1:0]=0.
- Writes to mtvec force bits[1:0]=0 (direct mode only).
- mstatus and mcause are written with all bits.

regs_* visibility: regs_* reflect register contents combinationally. A write performed at an edge is visible on regs_* immediately after that edge.

Boundary cases:
- csr_req and trap asserted in the same IDLE cycle: the trap wins; the CSR request waits and is accepted in the first IDLE cycle after TRAP_DONE.
- CSR write to mtvec followed immediately by a trap: the trap vector uses the new mtvec.
- mret with mepc=0: redirect_pc=0, no special handling.
- Back-to-back requests: at most one accept per IDLE cycle; IDLE lasts at least one cycle between sequences.

Optional Feature:
- Macro: CSR_MSTATUS_STACK_EN.
- Defined, trap entry (TRAP_CAUSE step):
  - MPIE(bit7) <= MIE(bit3).
  - MIE <= 0.
  - MPP(bits12:11) <= 2'b11.
- Defined, MRET:
  - MIE <= MPIE.
  - MPIE <= 1.
  - MPP <= 2'b11.
- Not defined: mstatus changes only through CSR instructions; trap and mret never modify it.

Test Plan:
- Reset check: reset=0 for 2 cycles -> regs_0=0x1800, regs_1..3=0, busy=0, all ready=1 except where masked by valid.
- CSR RW: csrrw 0x305 with wdata=0x80000103 -> csr_resp_valid 2 cycles after accept with rdata=0; regs_1=0x80000100.
- CSR RS then RC on 0x300: RS wdata=0x8 -> rdata=0x1800, regs_0=0x1808; RC wdata=0x1000 -> rdata=0x1808, regs_0=0x0808.
- Trap: mtvec=0x80000100, trap_pc=0x80000046, trap_cause=11 -> regs_2=0x80000044, regs_3=11; redirect_valid with redirect_pc=0x80000100 exactly 3 cycles after accept; csr_req held valid in the same cycle is accepted only after the trap completes.
- Mret plus illegal access: mret with mepc=0x80000044 -> redirect_pc=0x80000044 one cycle after accept; csrrs on 0x7C0 -> rdata=0, csr_illegal=1, no regs_* change.
- Reset mid-trap: assert reset in the TRAP_CAUSE cycle -> next cycle state IDLE, mcause=0, no redirect_valid pulse. With CSR_MSTATUS_STACK_EN, a trap from mstatus=0x1808 -> 0x1880, and mret -> 0x1888.
